// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer:
// operation codes, FSM state encodings and an op-decode helper.
package muldiv_seq_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } md_kind_t;

  // Bit 1 of the op selects divide, bit 0 selects the unsigned variant.
  function automatic md_kind_t md_decode(input logic [1:0] op);
    md_kind_t k;
    k.is_div    = op[1];
    k.is_signed = ~op[0];
    return k;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between the EX stage and the mul/div sequencer.
interface muldiv_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             rd_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata, rd_req,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata, rd_req,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, shift/trial-subtract/restore
// for divide, sharing a single WIDTH+1 bit adder.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             cin;
  logic [WIDTH+1:0] sum;

  always_comb begin
    // Divide subtracts from the remainder already shifted left by one;
    // multiply conditionally adds the multiplicand to the product's upper half.
    if (is_div) begin
      add_a = acc[2*WIDTH-1:WIDTH-1];
      add_b = ~{1'b0, operand};
      cin   = 1'b1;
    end else begin
      add_a = {1'b0, acc[2*WIDTH-1:WIDTH]};
      add_b = acc[0] ? {1'b0, operand} : '0;
      cin   = 1'b0;
    end

    sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, cin};

    // Carry out of the subtract means no borrow: keep the difference.
    if (is_div) begin
      acc_next = sum[WIDTH+1] ? {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                              : {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum[WIDTH:0], acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiply exits once the remaining multiplier bits are zero.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic        clk,
  input logic        rst_n,
  muldiv_seq_if.slave bus
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               q_neg;
  logic               r_neg;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;

  md_kind_t           kind;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] step_next;

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0]   mplier_rem;
  logic [CNT_W-1:0]   shamt;
  assign shamt = CNT_W'(WIDTH-1) - cnt;
`endif

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign kind  = md_decode(bus.op);
  assign a_abs = (kind.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs = (kind.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .is_div   (is_div),
    .acc_next (step_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      mplier_rem <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      if (bus.flush) begin
        state <= MD_IDLE;
      end else begin
        case (state)
          MD_IDLE: begin
            if (bus.start) begin
              is_div <= kind.is_div;
              cnt    <= '0;
              if (kind.is_div && bus.b == '0) begin
                // Divide by zero: remainder slot carries raw a, quotient all-ones.
                acc   <= {bus.a, {WIDTH{1'b1}}};
                q_neg <= 1'b0;
                r_neg <= 1'b0;
                state <= MD_FIX;
              end else if (kind.is_div) begin
                acc   <= {{WIDTH{1'b0}}, a_abs};
                opnd  <= b_abs;
                q_neg <= kind.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg <= kind.is_signed & bus.a[WIDTH-1];
                state <= MD_CALC;
              end else begin
                acc   <= {{WIDTH{1'b0}}, b_abs};
                opnd  <= a_abs;
                q_neg <= kind.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                mplier_rem <= b_abs;
                state      <= (b_abs == '0) ? MD_FIX : MD_CALC;
`else
                state <= MD_CALC;
`endif
              end
            end else begin
              if (bus.hi_we) hi_r <= bus.wdata;
              if (bus.lo_we) lo_r <= bus.wdata;
            end
          end

          MD_CALC: begin
            acc <= step_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH-1)) state <= MD_FIX;
`ifdef MULDIV_EARLY_OUT_EN
            if (!is_div) begin
              mplier_rem <= mplier_rem >> 1;
              // Remaining iterations would only shift; do them in one go.
              if (mplier_rem[WIDTH-1:1] == '0) begin
                acc   <= step_next >> shamt;
                state <= MD_FIX;
              end
            end
`endif
          end

          MD_FIX: begin
            if (is_div) begin
              hi_r <= cond_neg(acc[2*WIDTH-1:WIDTH], r_neg);
              lo_r <= cond_neg(acc[WIDTH-1:0], q_neg);
            end else begin
              {hi_r, lo_r} <= cond_neg_wide(acc, q_neg);
            end
            done_r <= 1'b1;
            state  <= MD_IDLE;
          end

          default: state <= MD_IDLE;
        endcase
      end
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.done  = done_r;
  assign bus.busy  = (state != MD_IDLE);
  assign bus.stall = bus.busy & (bus.rd_req | bus.start);

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed cases plus random ops against an arithmetic reference.
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  muldiv_seq_if #(.WIDTH(W)) bus();

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
    int l;
    l = W + 2;
    if (op[1] && b == 32'd0) l = 2;
`ifdef MULDIV_EARLY_OUT_EN
    else if (!op[1]) begin
      logic [31:0] mb;
      mb = (op == 2'd0 && b[31]) ? -b : b;
      l = 2;
      for (int i = 0; i < W; i++) if (mb[i]) l = 2 + i + 1;
    end
`endif
    return l;
  endfunction

  function automatic logic [63:0] exp_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int elat);
    int k;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    while (bus.done !== 1'b1 && k < W + 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: done=%b after %0d cycles", nm, bus.done, k);
      return;
    end
    checks++;
    if (k != elat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", nm, k, elat);
    end
    checks++;
    if ({bus.hi, bus.lo} !== {ehi, elo}) begin
      failures++;
      $display("FAIL %s result: hi=%h lo=%h want hi=%h lo=%h (a=%h b=%h op=%0d)", nm, bus.hi, bus.lo, ehi, elo, a, b, op);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b want 0 0", nm, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo: hi=%h lo=%h want 0 0", bus.hi, bus.lo);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b done=%b stall=%b want 0 0 0", bus.busy, bus.done, bus.stall);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, exp_latency(2'd0, 32'd3));
    run_op("multu", 2'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, exp_latency(2'd1, 32'd3));
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 2);
    run_op("divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, W + 2);
    run_op("divu_by0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, W + 2);
    run_op("mult_zero", 2'd0, 32'h1234_5678, 32'd0, 32'd0, 32'd0, exp_latency(2'd0, 32'd0));
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    int sel;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 255)) : $urandom;
      {ehi, elo} = exp_result(op, a, b);
      run_op("random", op, a, b, ehi, elo, exp_latency(op, b));
    end
  endtask

  task automatic test_mthi_flush();
    int seen;
    logic [31:0] mb;
`ifdef MULDIV_EARLY_OUT_EN
    mb = 32'h4000_0004;
`else
    mb = 32'd4;
`endif
    @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'd0;
    @(negedge clk); bus.lo_we = 1'b0;
    checks++;
    if (bus.hi !== 32'h1234 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h want 00001234 0", bus.hi, bus.lo);
    end
    bus.op = 2'd1; bus.a = 32'd3; bus.b = mb; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: busy=%b want 0", bus.busy);
    end
    seen = 0;
    repeat (W + 4) begin
      if (bus.done === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_done: done pulses=%0d want 0", seen);
    end
    checks++;
    if (bus.hi !== 32'h1234 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL flush_hilo: hi=%h lo=%h want 00001234 0", bus.hi, bus.lo);
    end
  endtask

  task automatic test_dropped_writes();
    @(negedge clk); bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_0001;
    @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++;
    if (bus.hi !== 32'hCAFE_0001 || bus.lo !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL mt_both: hi=%h lo=%h want cafe0001 cafe0001", bus.hi, bus.lo);
    end
    bus.op = 2'd1; bus.a = 32'd5; bus.b = 32'hFFFF_FFFF; bus.start = 1'b1;
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_BEEF;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0;
    checks++;
    if (bus.hi !== 32'hCAFE_0001 || bus.lo !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL mt_dropped: hi=%h lo=%h want cafe0001 cafe0001", bus.hi, bus.lo);
    end
  endtask

  task automatic test_stall();
    int k, bad;
    @(negedge clk);
    bus.rd_req = 1'b1; bus.op = 2'd1; bus.a = 32'd7; bus.b = 32'd9; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    k = 1; bad = 0;
    while (bus.done !== 1'b1 && k < W + 10) begin
      if (bus.stall !== 1'b1 || bus.busy !== 1'b1) bad++;
      if (k == 2) begin
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd100; bus.b = 32'd7;
      end else bus.start = 1'b0;
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_busy: %0d busy cycles without stall", bad);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd63) begin
      failures++;
      $display("FAIL stall_result: done=%b hi=%h lo=%h want 1 0 3f", bus.done, bus.hi, bus.lo);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL stall_at_done: stall=%b want 0", bus.stall);
    end
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_after: stall=%b busy=%b want 0 0", bus.stall, bus.busy);
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk); bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
    @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.op = 2'd2; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b want all 0", bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op("after_reset", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, W + 2);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.rd_req = 1'b0;
    test_reset();
    test_directed();
    test_mthi_flush();
    test_dropped_writes();
    test_stall();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
